// File: rtl/sram_cfg_pkg.sv
// Shared configuration package for the 8/16/32-bit SRAM wrapper.
// Holds the conf encodings, lane/mask widths, the {conf, lane} read tag and
// helpers for lane extraction, byte-mask generation and write-lane alignment.
// Also used by the downstream output shifter.
package sram_cfg_pkg;

  localparam logic [1:0] CONF_32  = 2'b00;
  localparam logic [1:0] CONF_16  = 2'b01;
  localparam logic [1:0] CONF_8   = 2'b10;
  localparam logic [1:0] CONF_ILL = 2'b11;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned MASK_W = 4;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [MASK_W-1:0] mask_t;

  typedef struct packed {
    logic [1:0] conf;
    lane_t      lane;
  } rd_tag_t;

  localparam int unsigned TAG_W = $bits(rd_tag_t);

  // Lane within the 32-bit word; illegal conf behaves as 32b.
  function automatic lane_t lane_of(logic [1:0] conf, logic [1:0] addr_lo);
    case (conf)
      CONF_16: return {1'b0, addr_lo[0]};
      CONF_8:  return addr_lo;
      default: return '0;
    endcase
  endfunction

  function automatic mask_t mask_of(logic [1:0] conf, lane_t lane);
    case (conf)
      CONF_16: return lane[0] ? 4'b1100 : 4'b0011;
      CONF_8:  return mask_t'(1) << lane;
      default: return 4'b1111;
    endcase
  endfunction

  // Moves right-justified write data into its lane; unselected bits are zero.
  function automatic logic [DATA_W-1:0] align_wdata(logic [1:0] conf, lane_t lane,
                                                    logic [DATA_W-1:0] wdata);
    case (conf)
      CONF_16: return lane[0] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
      CONF_8:  return {24'h000000, wdata[7:0]} << {lane, 3'b000};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/sram_req_front_8_32_if.sv
// Bus bundle for sram_req_front_8_32: request channel, SRAM macro command
// and read-data signals, and response channel.
// Modports: slave = the front end itself, master = its environment.
interface sram_req_front_8_32_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_conf;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_conf;
  logic [1:0]        rsp_lane;

  modport slave (
    input  req_valid, req_we, req_conf, req_addr, req_wdata, mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    output rsp_valid, rsp_data, rsp_conf, rsp_lane
  );

  modport master (
    output req_valid, req_we, req_conf, req_addr, req_wdata, mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  rsp_valid, rsp_data, rsp_conf, rsp_lane
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through FIFO for read responses ({data, tag} entries).
// Ports: clk, rst_n (async active-low), push_i/data_i write side,
// valid_o/ready_i/data_o read side (data_o shows the head while valid_o=1).
// Pointers wrap modulo Depth, so Depth need not be a power of two.
// The caller guarantees no push while full.
module sram_rsp_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (pop)    rptr_q <= ptr_inc(rptr_q);
      if (push_i && !pop)      count_q <= count_q + CntW'(1);
      else if (!push_i && pop) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/sram_req_front_8_32.sv
// Request-side front end for the 8/16/32-bit SRAM wrapper.
// Accepts read/write requests (valid/ready), issues registered commands to a
// 32-bit SRAM macro with lane-aligned write data and byte mask, and returns
// raw read words tagged with {conf, lane} through a response FIFO.
// Ports: clk, rst_n (async active-low), bus (sram_req_front_8_32_if.slave),
// and err (only when SRAM_REQ_FRONT_ERR_EN is defined: sticky flag for
// illegal conf or narrow-view out-of-range addresses; such requests are
// accepted but never issued).
// Flow control: a credit counts reads in flight plus FIFO occupancy; requests
// are only accepted while credit < FIFO_DEPTH so the FIFO cannot overflow.
module sram_req_front_8_32
  import sram_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sram_req_front_8_32_if.slave        bus
`ifdef SRAM_REQ_FRONT_ERR_EN
  ,
  output logic                        err
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = DATA_W + TAG_W;

  logic [CntW-1:0]   credit_q, credit_d;
  logic              accept, issue, rd_accept, pop;
  lane_t             lane;
  logic [ADDR_W-1:0] mem_addr_d;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  mask_t             mem_wmask_q;
  rd_tag_t           tag_q;

  logic [READ_LAT-1:0] pipe_vld_q;
  rd_tag_t             pipe_tag_q [READ_LAT];

  logic            fifo_push;
  logic [EntW-1:0] fifo_wdata, fifo_head;
  rd_tag_t         head_tag;

  // Ready depends on registered credit only.
  assign bus.req_ready = (credit_q < CntW'(FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign lane          = lane_of(bus.req_conf, bus.req_addr[1:0]);

`ifdef SRAM_REQ_FRONT_ERR_EN
  logic range_bad, err_q;

  always_comb begin
    case (bus.req_conf)
      CONF_16:  range_bad = bus.req_addr[ADDR_W-1];
      CONF_8:   range_bad = (bus.req_addr[ADDR_W-1:ADDR_W-2] != 2'b00);
      CONF_ILL: range_bad = 1'b1;
      default:  range_bad = 1'b0;
    endcase
  end

  assign issue = accept && !range_bad;
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept && range_bad) err_q <= 1'b1;
  end
`else
  assign issue = accept;
`endif

  assign rd_accept = issue && !bus.req_we;
  assign pop       = bus.rsp_valid && bus.rsp_ready;

  // Narrow address to macro word address; upper bits zero-fill.
  always_comb begin
    case (bus.req_conf)
      CONF_16: mem_addr_d = bus.req_addr >> 1;
      CONF_8:  mem_addr_d = bus.req_addr >> 2;
      default: mem_addr_d = bus.req_addr;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (rd_accept && !pop)      credit_d = credit_q + CntW'(1);
    else if (!rd_accept && pop) credit_d = credit_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      tag_q       <= '0;
    end else begin
      credit_q <= credit_d;
      mem_en_q <= issue;
      mem_we_q <= issue && bus.req_we;
      if (issue) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= bus.req_we ? align_wdata(bus.req_conf, lane, bus.req_wdata) : '0;
        mem_wmask_q <= bus.req_we ? mask_of(bus.req_conf, lane) : '0;
        tag_q       <= '{conf: bus.req_conf, lane: lane};
      end
    end
  end

  // Tag travels alongside the macro access so it meets mem_rdata on arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= mem_en_q && !mem_we_q;
      pipe_tag_q[0] <= tag_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign fifo_push  = pipe_vld_q[READ_LAT-1];
  assign fifo_wdata = {bus.mem_rdata, pipe_tag_q[READ_LAT-1]};

  sram_rsp_fifo #(
    .Width (EntW),
    .Depth (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .valid_o (bus.rsp_valid),
    .ready_i (bus.rsp_ready),
    .data_o  (fifo_head)
  );

  assign head_tag     = rd_tag_t'(fifo_head[TAG_W-1:0]);
  assign bus.rsp_data = fifo_head[EntW-1:TAG_W];
  assign bus.rsp_conf = head_tag.conf;
  assign bus.rsp_lane = head_tag.lane;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_sram_req_front_8_32.sv
// Self-checking bench for sram_req_front_8_32 (READ_LAT=1, FIFO_DEPTH=4).
// A behavioural macro model answers reads; a reference model computes the
// expected command for each accepted request and the expected response for
// each read, queued and compared by a negedge monitor.
module tb_sram_req_front_8_32;
  import sram_cfg_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned FD = 4;
  localparam int unsigned NW = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_req_front_8_32_if #(.ADDR_W(AW)) bus ();

`ifdef SRAM_REQ_FRONT_ERR_EN
  logic err;
`endif

  sram_req_front_8_32 #(
    .ADDR_W     (AW),
    .READ_LAT   (1),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SRAM_REQ_FRONT_ERR_EN
    ,
    .err   (err)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(int i);
    return (i * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // ---------------- macro model (1-cycle read latency) ----------------
  bit [31:0] macro_mem [NW];
  bit        macro_wr  [NW];

  initial bus.mem_rdata = '0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        if (!macro_wr[bus.mem_addr]) macro_mem[bus.mem_addr] = pat(int'(bus.mem_addr));
        macro_wr[bus.mem_addr] = 1'b1;
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) macro_mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= macro_wr[bus.mem_addr] ? macro_mem[bus.mem_addr]
                                                : pat(int'(bus.mem_addr));
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   wdata;
    logic [3:0]    mask;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  conf;
    logic [1:0]  lane;
  } rsp_t;

  cmd_t      cmd_q[$];
  rsp_t      rsp_q[$];
  int        credit = 0;
  bit [31:0] ref_mem [NW];
  bit        ref_wr  [NW];

  // A request covers nb bytes starting at byte off of word addr/(4/nb).
  task automatic model_accept(logic we, logic [1:0] conf, logic [AW-1:0] addr,
                              logic [31:0] wdata);
    int   nb, per, word, lane, off;
    cmd_t c;
    rsp_t r;
    nb   = (conf == 2'b01) ? 2 : (conf == 2'b10) ? 1 : 4;
    per  = 4 / nb;
    word = int'(addr) / per;
    lane = int'(addr) % per;
    off  = lane * nb;
    c.addr  = word[AW-1:0];
    c.we    = we;
    c.wdata = '0;
    c.mask  = '0;
    if (!ref_wr[word]) ref_mem[word] = pat(word);
    if (we) begin
      ref_wr[word] = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + nb) begin
          c.mask[b]          = 1'b1;
          c.wdata[8*b +: 8]  = wdata[8*(b-off) +: 8];
          ref_mem[word][8*b +: 8] = wdata[8*(b-off) +: 8];
        end
      end
    end else begin
      r.data = ref_mem[word];
      r.conf = conf;
      r.lane = lane[1:0];
      rsp_q.push_back(r);
      credit++;
    end
    cmd_q.push_back(c);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    if (!rst_n) begin
      cmd_q.delete();
      rsp_q.delete();
      credit = 0;
    end else begin
      chk("req_ready", {63'b0, bus.req_ready}, {63'b0, credit < FD});
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        chk("mem_en", {63'b0, bus.mem_en}, 64'd1);
        chk("mem_we", {63'b0, bus.mem_we}, {63'b0, c.we});
        chk("mem_addr", {52'b0, bus.mem_addr}, {52'b0, c.addr});
        chk("mem_wmask", {60'b0, bus.mem_wmask}, {60'b0, c.mask});
        if (c.we) chk("mem_wdata", {32'b0, bus.mem_wdata}, {32'b0, c.wdata});
      end else begin
        chk("mem_en_idle", {63'b0, bus.mem_en}, 64'd0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_spurious", 64'd1, 64'd0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_data", {32'b0, bus.rsp_data}, {32'b0, r.data});
          chk("rsp_conf", {62'b0, bus.rsp_conf}, {62'b0, r.conf});
          chk("rsp_lane", {62'b0, bus.rsp_lane}, {62'b0, r.lane});
        end
        credit--;
      end
      if (bus.req_valid && bus.req_ready)
        model_accept(bus.req_we, bus.req_conf, bus.req_addr, bus.req_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(logic we, logic [1:0] conf, logic [AW-1:0] addr, logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_conf  = conf;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  // Called at posedge+1 with req_valid high; returns at posedge+1 after acceptance.
  task automatic wait_acc();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send(logic we, logic [1:0] conf, logic [AW-1:0] addr, logic [31:0] wd);
    drive(we, conf, addr, wd);
    wait_acc();
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((credit != 0 || rsp_q.size() != 0) && n < 100) begin
      step(1);
      n++;
    end
    chk("drain_done", {63'b0, n < 100}, 64'd1);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  bit done;

  initial begin
    logic [1:0]    conf;
    logic [AW-1:0] addr;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_conf  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", {63'b0, bus.mem_en}, 64'd0);
    chk("rst_mem_we", {63'b0, bus.mem_we}, 64'd0);
    chk("rst_mem_addr", {52'b0, bus.mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'b0, bus.mem_wdata}, 64'd0);
    chk("rst_mem_wmask", {60'b0, bus.mem_wmask}, 64'd0);
    chk("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd1);
    step(1);

    // Directed write alignment
    send(1'b1, CONF_8, 12'h006, 32'h000000A5);
    chk("w8_we", {63'b0, bus.mem_we}, 64'd1);
    chk("w8_addr", {52'b0, bus.mem_addr}, 64'h001);
    chk("w8_wdata", {32'b0, bus.mem_wdata}, 64'h00A50000);
    chk("w8_wmask", {60'b0, bus.mem_wmask}, 64'b0100);
    send(1'b1, CONF_16, 12'h003, 32'h0000BEEF);
    chk("w16_addr", {52'b0, bus.mem_addr}, 64'h001);
    chk("w16_wdata", {32'b0, bus.mem_wdata}, 64'hBEEF0000);
    chk("w16_wmask", {60'b0, bus.mem_wmask}, 64'b1100);
    send(1'b1, CONF_32, 12'h001, 32'h11223344);
    chk("w32_wmask", {60'b0, bus.mem_wmask}, 64'b1111);

    // Directed 8b read and its latency
    send(1'b0, CONF_8, 12'h007, 32'h0);
    chk("r8_wmask", {60'b0, bus.mem_wmask}, 64'd0);
    @(negedge clk);
    chk("r8_lat1", {63'b0, bus.rsp_valid}, 64'd0);
    @(negedge clk);
    chk("r8_lat2", {63'b0, bus.rsp_valid}, 64'd0);
    @(negedge clk);
    chk("r8_lat3", {63'b0, bus.rsp_valid}, 64'd1);
    chk("r8_data", {32'b0, bus.rsp_data}, 64'h11223344);
    chk("r8_conf", {62'b0, bus.rsp_conf}, 64'b10);
    chk("r8_lane", {62'b0, bus.rsp_lane}, 64'b11);
    step(1);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;

    // Credit exhaustion: 5 reads, FIFO_DEPTH=4
    for (int i = 0; i < 4; i++) send(1'b0, CONF_32, AW'(16 + i), 32'h0);
    drive(1'b0, CONF_32, 12'h020, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_stall", {63'b0, bus.req_ready}, 64'd0);
    end
    step(1);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    wait_acc();
    @(negedge clk);
    chk("full_again", {63'b0, bus.req_ready}, 64'd0);
    step(1);
    drain();

    // Same-cycle accept and pop at credit 3
    for (int i = 0; i < 3; i++) send(1'b0, CONF_16, AW'(40 + i), 32'h0);
    step(3);
    drive(1'b0, CONF_8, 12'h033, 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("c3_ready", {63'b0, bus.req_ready}, 64'd1);
    chk("c3_rsp_valid", {63'b0, bus.rsp_valid}, 64'd1);
    step(1);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("c3_ready_after", {63'b0, bus.req_ready}, 64'd1);
    step(1);
    drain();

    // Reset with reads in flight and one response queued
    send(1'b0, CONF_32, 12'h005, 32'h0);
    step(3);
    send(1'b0, CONF_32, 12'h006, 32'h0);
    send(1'b0, CONF_32, 12'h007, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_mem_en", {63'b0, bus.mem_en}, 64'd0);
    step(2);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {63'b0, bus.rsp_valid}, 64'd0);
    end
    step(1);
    bus.rsp_ready = 1'b0;

    // Randomized traffic with random response back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          conf = 2'($urandom_range(0, 3));
          addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
`ifdef SRAM_REQ_FRONT_ERR_EN
          if (conf == 2'b11) conf = CONF_32;
          addr[AW-1:AW-2] = 2'b00;
`endif
          if ($urandom_range(0, 4) == 0) step(1);
          send(1'($urandom_range(0, 1)), conf, addr, $urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step(1);
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    step(2);
    chk("final_rsp_queue", 64'(rsp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_req_front_8_32.md
Name: sram_req_front_8_32

Overview:
- Request-side front end for the configurable 8/16/32-bit SRAM wrapper.
- Accepts read/write requests over a valid/ready channel and issues registered commands to the 32-bit SRAM macro.
- On writes: aligns write data into the correct lane and generates a 4-bit byte mask.
- On reads: carries conf and lane alongside the read data through READ_LAT cycles, buffers them in a response FIFO, and presents them to the downstream output shifter, which selects the narrow word.

Parameters:
- ADDR_W, 12, request address width in narrow-word units.
- READ_LAT, 1, macro read latency in cycles from the mem_en cycle to mem_rdata valid.
- FIFO_DEPTH, 4, response FIFO entries; must be >= READ_LAT+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_we  in  1  1=write, 0=read
- req_conf  in  2  00=32b, 01=16b, 10=8b, 11=illegal
- req_addr  in  ADDR_W  narrow-word address
- req_wdata  in  32  write data, right-justified
- mem_en  out  1  macro enable
- mem_we  out  1  macro write enable
- mem_addr  out  ADDR_W  macro word address
- mem_wdata  out  32  lane-aligned write data
- mem_wmask  out  4  byte write mask; bit k covers bits 8k+7:8k
- mem_rdata  in  32  macro read data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_data  out  32  raw 32-bit read word
- rsp_conf  out  2  conf of the originating request
- rsp_lane  out  2  lane of the originating request (addr[1:0] for 8b, {0,addr[0]} for 16b, 00 for 32b)

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, rsp_valid=0, FIFO empty, credit count 0, delay pipeline cleared.
- Handshake and issue:
  - A request is accepted when req_valid && req_ready.
  - req_ready depends only on internal state, with no combinational path from req_*.
  - mem_* are registered and assert exactly one cycle after acceptance. mem_en drops when no request is accepted.
- Address mapping:
  - 32b: mem_addr = req_addr, lane = 00.
  - 16b: mem_addr = req_addr >> 1, lane = {0, req_addr[0]}.
  - 8b: mem_addr = req_addr >> 2, lane = req_addr[1:0].
  - Upper bits are zero-filled.
- Write alignment:
  - 32b: data passes through; mask 1111.
  - 16b lane 0: data at [15:0], mask 0011. Lane 1: data at [31:16], mask 1100.
  - 8b lane k: data byte at [8k+7:8k], mask one-hot bit k.
  - Unselected data bits are 0.
  - Reads drive mem_wmask = 0000.
- Read tracking:
  - Each issued read pushes {conf, lane} into a READ_LAT-deep shift pipeline.
  - When that entry emerges, {mem_rdata, conf, lane} is written to the FIFO.
- Credits:
  - credit = reads in flight + FIFO occupancy.
  - req_ready = (credit < FIFO_DEPTH). Writes are also stalled at full credit.
  - A read accept increments credit; a FIFO pop (rsp_valid && rsp_ready) decrements it.
  - A read accept and a pop in the same cycle leave credit unchanged.
- Response FIFO:
  - First-word fall-through: rsp_* reflect the head entry while rsp_valid=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - The credit scheme guarantees the FIFO never overflows.
  - Push into an empty FIFO: rsp_valid rises the following cycle.
- Illegal conf 11 (feature off): treated as 32b.
- Reset mid-operation: in-flight reads and FIFO contents are discarded, and no response is produced for them.

Optional Feature:
- Macro: SRAM_REQ_FRONT_ERR_EN.
- Defined:
  - Adds output err (1 bit, sticky, reset 0).
  - err sets on acceptance of a request with conf 11, or with 16b and req_addr[ADDR_W-1]=1, or with 8b and req_addr[ADDR_W-1:ADDR_W-2] != 0 (out of range for the narrow view).
  - Such requests are accepted but not issued: mem_en stays 0 and no response is generated.
- Undefined: the err port is absent, no range checks are made, and conf 11 behaves as 32b.

Decomposition:
- Shared package sram_cfg_pkg holds:
  - conf encodings: CONF_32=2'b00, CONF_16=2'b01, CONF_8=2'b10.
  - lane and mask widths.
  - a typedef for the {conf, lane} read tag.
  - The output shifter uses the same package.
- Natural sub-module: sram_rsp_fifo, a parameterized first-word-fall-through FIFO of {data, tag}.

Test Plan:
- 8b write, addr=0x006, wdata=0x000000A5 -> next cycle mem_addr=0x001, mem_wdata=0x00A50000, mem_wmask=0100, mem_we=1.
- 16b write, addr=0x003, wdata=0x0000BEEF -> mem_addr=0x001, mem_wdata=0xBEEF0000, mem_wmask=1100.
- 8b read, addr=0x007, READ_LAT=1, macro returns 0x11223344 -> rsp_data=0x11223344, rsp_conf=10, rsp_lane=11, and rsp_valid rises 3 cycles after acceptance.
- 5 back-to-back reads, FIFO_DEPTH=4, rsp_ready=0 -> 4 accepted and req_ready=0. Pulse rsp_ready for one cycle -> exactly one more read accepted; responses come out in order.
- Same-cycle read accept and FIFO pop at credit=3 -> credit stays 3 and req_ready stays 1.
- Assert rst_n low with 2 reads in flight -> rsp_valid=0 and mem_en=0 immediately. After release, no stale responses appear.
